// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared types and constants for the divided-clock meter.
//   state_t    : meter FSM states (IDLE/ARM/HIGH/LOW), 2-bit encoding
//   CNT_W_DEF  : default phase counter width
// -----------------------------------------------------------------------------
package clk_div_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchronizer for a single-bit level.
// Ports:
//   clk  in  : destination clock
//   rstn in  : asynchronous active-low reset, both flops clear to 0
//   d    in  : asynchronous input level
//   q    out : synchronized level, two clk edges behind d
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_div_meter.sv
// -----------------------------------------------------------------------------
// clk_div_meter
// Measures the high phase, low phase and period of a divided clock in cycles
// of the reference clock clk. clk_in is sampled as data only.
//
// Build option:
//   CLK_DIV_METER_SYNC_EN  defined: clk_in goes through sync_2ff (2 cycles of
//                          extra latency, phases may jitter by +/-1).
//                          undefined: clk_in is used directly (it must be
//                          produced by registers on clk); results are exact.
//
// Ports:
//   clk        in  : reference clock, rising edge
//   rstn       in  : asynchronous active-low reset
//   clk_in     in  : divided clock under measurement
//   en         in  : measurement enable; low returns to IDLE, results hold
//   high_len   out : cycles high in the last complete period
//   low_len    out : cycles low in the last complete period
//   period     out : high_len + low_len (one bit wider, cannot overflow)
//   is_even    out : period is even
//   duty_ok    out : high_len == low_len
//   meas_valid out : one-cycle pulse, result outputs updated on this edge
//   timeout    out : one-cycle pulse, a phase counter saturated
//   state      out : current FSM state (debug)
//
// Result handshake: meas_valid is a valid-only strobe with no ready; the
// result registers change only on a meas_valid edge (or reset) and stay
// stable until the next one, so a consumer may sample them at any time.
// -----------------------------------------------------------------------------
module clk_div_meter
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clk_in,
  input  logic             en,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] low_len,
  output logic [CNT_W:0]   period,
  output logic             is_even,
  output logic             duty_ok,
  output logic             meas_valid,
  output logic             timeout,
  output state_t           state
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             s;
  logic             s_d;
  logic             rise;
  logic             fall;
  logic             sat;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_tmp;

`ifdef CLK_DIV_METER_SYNC_EN
  sync_2ff u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (clk_in),
    .q    (s)
  );
`else
  assign s = clk_in;
`endif

  assign rise = s & ~s_d;
  assign fall = ~s & s_d;
  assign sat  = (cnt == CNT_MAX);

  // Each phase counter starts at 1 on the edge that detects the phase change,
  // so the count captured at the next change equals the phase length. An edge
  // is checked before saturation so a phase of exactly CNT_MAX is still
  // measured rather than timed out.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      s_d        <= 1'b0;
      cnt        <= '0;
      hi_tmp     <= '0;
      high_len   <= '0;
      low_len    <= '0;
      period     <= '0;
      is_even    <= 1'b1;
      duty_ok    <= 1'b1;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      s_d        <= s;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      if (!en) begin
        state  <= ST_IDLE;
        cnt    <= '0;
        hi_tmp <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            cnt   <= '0;
            state <= ST_ARM;
          end
          ST_ARM: begin
            // Wait for a clean rise so the first partial period is dropped.
            if (rise) begin
              cnt   <= CNT_ONE;
              state <= ST_HIGH;
            end
          end
          ST_HIGH: begin
            if (fall) begin
              hi_tmp <= cnt;
              cnt    <= CNT_ONE;
              state  <= ST_LOW;
            end else if (sat) begin
              timeout <= 1'b1;
              cnt     <= '0;
              state   <= ST_ARM;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          ST_LOW: begin
            if (rise) begin
              high_len   <= hi_tmp;
              low_len    <= cnt;
              period     <= {1'b0, hi_tmp} + {1'b0, cnt};
              is_even    <= ~(hi_tmp[0] ^ cnt[0]);
              duty_ok    <= (hi_tmp == cnt);
              meas_valid <= 1'b1;
              cnt        <= CNT_ONE;
              state      <= ST_HIGH;
            end else if (sat) begin
              timeout <= 1'b1;
              cnt     <= '0;
              state   <= ST_ARM;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            cnt   <= '0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_div_meter.sv
// -----------------------------------------------------------------------------
// tb_clk_div_meter
// Drives clk_in as a register-generated waveform described by (high, low)
// phase lengths. Every complete period the driver produces is pushed into
// exp_q; a monitor pops one entry per meas_valid and compares all result
// fields against values derived from the phase lengths.
// -----------------------------------------------------------------------------
module tb_clk_div_meter;
  import clk_div_pkg::*;

  localparam int W = 4;

  // clock / reset
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic         clk_in = 1'b0;
  logic         en     = 1'b0;
  logic [W-1:0] high_len;
  logic [W-1:0] low_len;
  logic [W:0]   period;
  logic         is_even;
  logic         duty_ok;
  logic         meas_valid;
  logic         timeout;
  state_t       dut_state;

  clk_div_meter #(.CNT_W(W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .clk_in     (clk_in),
    .en         (en),
    .high_len   (high_len),
    .low_len    (low_len),
    .period     (period),
    .is_even    (is_even),
    .duty_ok    (duty_ok),
    .meas_valid (meas_valid),
    .timeout    (timeout),
    .state      (dut_state)
  );

  int checks        = 0;
  int failures      = 0;
  int exp_timeouts  = 0;
  int seen_timeouts = 0;
  int last_h        = 0;
  int last_l        = 0;
  logic [2*W-1:0] exp_q[$];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // scoreboard monitor
  logic [2*W-1:0] mon_e;
  int mon_h, mon_l, mon_p;
  always @(negedge clk) begin
    if (rstn) begin
      if (timeout) seen_timeouts++;
      if (meas_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_meas_valid: got high_len=%0d low_len=%0d expected no result",
                   high_len, low_len);
        end else begin
          mon_e = exp_q.pop_front();
          mon_h = int'(mon_e[2*W-1:W]);
          mon_l = int'(mon_e[W-1:0]);
          mon_p = mon_h + mon_l;
          check("high_len", int'(high_len), mon_h);
          check("low_len",  int'(low_len),  mon_l);
          check("period",   int'(period),   mon_p);
          check("is_even",  int'(is_even),  (mon_p % 2 == 0) ? 1 : 0);
          check("duty_ok",  int'(duty_ok),  (mon_h == mon_l) ? 1 : 0);
        end
      end
    end
  end

  // driver tasks: every change happens 1 time unit after a rising edge
  task automatic hold(input logic v, input int n);
    clk_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_period(input int h, input int l);
    hold(1'b1, h);
    hold(1'b0, l);
    exp_q.push_back({W'(h), W'(l)});
    last_h = h;
    last_l = l;
  endtask

  task automatic check_hold(input string tag);
    check({tag, "_high_len"}, int'(high_len), last_h);
    check({tag, "_low_len"},  int'(low_len),  last_l);
    check({tag, "_period"},   int'(period),   last_h + last_l);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_high_len"},   int'(high_len),   0);
    check({tag, "_low_len"},    int'(low_len),    0);
    check({tag, "_period"},     int'(period),     0);
    check({tag, "_is_even"},    int'(is_even),    1);
    check({tag, "_duty_ok"},    int'(duty_ok),    1);
    check({tag, "_meas_valid"}, int'(meas_valid), 0);
    check({tag, "_timeout"},    int'(timeout),    0);
    check({tag, "_state"},      int'(dut_state),  int'(ST_IDLE));
  endtask

  task automatic start_burst();
    clk_in = 1'b0;
    en     = 1'b1;
    hold(1'b0, 3);
  endtask

  // Closing rise, a partial high phase, then en dropped mid-HIGH.
  task automatic end_burst();
    hold(1'b1, 5);
    en = 1'b0;
    hold(1'b1, 1);
    hold(1'b0, 6);
    check_hold("hold_after_en_drop");
    check("idle_after_en_drop", int'(dut_state), int'(ST_IDLE));
  endtask

  initial begin
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rstn = 1'b1;
    hold(1'b0, 2);

    // divide-by-10
    start_burst();
    for (int i = 0; i < 6; i++) drive_period(5, 5);
    end_burst();

    // divide-by-2, back-to-back
    start_burst();
    for (int i = 0; i < 100; i++) drive_period(1, 1);
    end_burst();

    // divide-by-5
    start_burst();
    for (int i = 0; i < 6; i++) drive_period(2, 3);
    end_burst();

    // random phase lengths
    for (int b = 0; b < 4; b++) begin
      start_burst();
      for (int i = 0; i < 8; i++)
        drive_period(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)));
      end_burst();
    end

    // stuck low inside LOW -> timeout, then divide-by-4 resumes
    start_burst();
    drive_period(2, 2);
    hold(1'b1, 2);
    hold(1'b0, 20);
    exp_timeouts++;
    check_hold("hold_after_timeout");
    check("timeout_count", seen_timeouts, exp_timeouts);
    check("arm_after_timeout", int'(dut_state), int'(ST_ARM));
    for (int i = 0; i < 5; i++) drive_period(2, 2);
    end_burst();

    // reset mid-LOW
    start_burst();
    drive_period(3, 3);
    drive_period(3, 3);
    hold(1'b1, 3);
    hold(1'b0, 5);
    #3;
    rstn = 1'b0;
    #1;
    check_reset_state("reset_mid_low");
    check("queue_empty_at_reset", exp_q.size(), 0);
    last_h = 0;
    last_l = 0;
    repeat (3) @(posedge clk);
    #4;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    hold(1'b0, 3);
    for (int i = 0; i < 4; i++) drive_period(4, 2);
    end_burst();

    hold(1'b0, 5);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_timeout_count", seen_timeouts, exp_timeouts);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
